cfg_chain_loader: RTL
=====================

# cfg_chain_loader

Sequencer that programs the io_block / CLB configuration shift chain from a word-wide bitstream source. It accepts configuration words over a valid/ready handshake, serialises them MSB-first onto `prog_in`, generates `prog_clk`, holds `prog_en` high while shifting, then drops `prog_en` so every block latches its new control bits. It sits between the bitstream source (host interface or boot ROM reader) and the head of the programming chain.

## Interface
- `CHAIN_LEN`, 24: total configuration bits in the chain; default is 8 io_blocks × 3 bits. Must be ≥ 1.
- `WORD_W`, 8: width of the incoming configuration word; ≥ 1.
- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `cfg_data`  in  WORD_W  configuration word, MSB shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  loader can accept a word this cycle.
- `prog_in`  out  1  serial data to chain head.
- `prog_clk`  out  1  chain shift clock, registered.
- `prog_en`  out  1  chain shift enable; its falling edge latches the configuration.
- `prog_out`  in  1  serial output from chain tail.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the load is complete and latched.
- `rb_data`  out  WORD_W  readback word; present only with `CFG_LOADER_READBACK_EN`.
- `rb_valid`  out  1  readback word strobe; present only with `CFG_LOADER_READBACK_EN`.

## Operation
- States: IDLE, WAIT_WORD, SHIFT_LO, SHIFT_HI, TAIL, LATCH, DONE.
- IDLE: all outputs 0. If `start` = 1, go to WAIT_WORD and clear the bit counter.
- WAIT_WORD:
  - `cfg_ready` = 1, `prog_en` = 1, `prog_clk` = 0.
  - On `cfg_valid && cfg_ready`: load the word register, set bit index = WORD_W−1, go to SHIFT_LO.
- SHIFT_LO: `prog_clk` = 0, `prog_in` = word[bit index]. Go to SHIFT_HI.
- SHIFT_HI: `prog_clk` = 1, which is the chain's sampling edge. Increment the bit counter, then:
  - If the counter reaches CHAIN_LEN, go to TAIL. Any unshifted bits of the current word are discarded.
  - Otherwise, if bit index = 0, go to WAIT_WORD.
  - Otherwise, decrement the bit index and go to SHIFT_LO.
- TAIL: `prog_clk` = 0, `prog_en` = 1. This is a one-cycle guard before the latch.
- LATCH: `prog_en` = 0; its falling edge latches the chain. Lasts one cycle.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Ordering: the first bit shifted ends up in the chain element farthest from the loader.
- `start` outside IDLE is ignored. `cfg_valid` outside WAIT_WORD is ignored, and the word is not consumed.
- The bit counter is ⌈log2(CHAIN_LEN+1)⌉ bits and does not wrap. The bit index is ⌈log2(WORD_W)⌉ bits.

## Timing
- All outputs are registered.
- Reset values: every output = 0, state = IDLE.
- Reset mid-load:
  - `prog_en` falls on the next edge, so the chain latches a partial configuration.
  - No `done` is generated; the source must restart with `start`.
- Per bit: 2 cycles. Per word: 1 handshake cycle plus 2 × (bits used).
- With `cfg_valid` held high, `start` sampled in cycle 0 gives `done` in cycle 1 + ⌈CHAIN_LEN/WORD_W⌉ + 2·CHAIN_LEN + 2. For the defaults this is cycle 54.
- Source stalls (`cfg_valid` = 0) extend WAIT_WORD indefinitely:
  - `prog_en` stays 1 and `prog_clk` stays 0.
  - No timeout.
- `prog_in` changes only in SHIFT_LO, so it is stable for a full cycle before every `prog_clk` rise.

## Configuration
- `CFG_LOADER_READBACK_EN` defined:
  - `prog_out` is sampled in every SHIFT_LO cycle and assembled MSB-first into `rb_data`.
  - `rb_valid` pulses for one cycle, in the cycle after the WORD_W-th sampled bit.
  - The final partial word, if any, is left-aligned with zero low bits. It is emitted in TAIL.
  - This streams out the previous configuration as the new one shifts in.
  - `rb_data` and `rb_valid` reset to 0.
- Not defined: `rb_data` and `rb_valid` are absent, `prog_out` is unused, and there are no readback registers.

## Test plan
- Defaults, words 0xA5, 0x3C, 0x0F offered with `cfg_valid` held high, `start` in cycle 0:
  - `prog_in` sequence at `prog_clk` rises = 101001010011110000001111.
  - `prog_en` falls in cycle 53 and `done` = 1 in cycle 54.
- CHAIN_LEN=20, words 0xFF, 0xFF, 0xF0:
  - Exactly 20 `prog_clk` rises occur.
  - The low 4 bits of the third word are never driven.
  - 3 handshakes, then TAIL.
- `cfg_valid` dropped for 10 cycles after the first word:
  - `prog_clk` holds 0, `prog_en` holds 1 and `cfg_ready` holds 1 throughout.
  - Resumes correctly; `done` is delayed by 10 cycles.
- `rst` asserted in the 5th SHIFT_HI:
  - Next cycle all outputs = 0 and state = IDLE.
  - A following `start` performs a full 24-bit load.
- `start` pulsed while busy:
  - Ignored, single `done`.
  - A `cfg_valid` pulse in IDLE yields `cfg_ready` = 0 and no state change.
- With `CFG_LOADER_READBACK_EN`, chain pre-loaded with 0x123456:
  - A new load produces `rb_valid` three times with `rb_data` 0x12, 0x34, 0x56.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises config words MSB-first onto the programming chain, then latches it with prog_en.
// Define CFG_LOADER_READBACK_EN to capture the old chain contents from prog_out onto rb_data/rb_valid.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              prog_in,
    output logic              prog_clk,
    output logic              prog_en,
    input  logic              prog_out,
    output logic              busy,
    output logic              done
`ifdef CFG_LOADER_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
    typedef enum logic [2:0] {IDLE, WAIT_WORD, SHIFT_LO, SHIFT_HI, TAIL, LATCH, DONE} state_t;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [WORD_W-1:0] r_word;
    logic              w_last;
    assign w_last = r_cnt == CW'(CHAIN_LEN - 1);
    // Outputs are registered, so each transition drives the values of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_word    <= '0;
            cfg_ready <= 1'b0;
            prog_in   <= 1'b0;
            prog_clk  <= 1'b0;
            prog_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state   <= WAIT_WORD;
                    r_cnt     <= '0;
                    cfg_ready <= 1'b1;
                    prog_en   <= 1'b1;
                    busy      <= 1'b1;
                end
                WAIT_WORD: if (cfg_valid) begin
                    r_state   <= SHIFT_LO;
                    r_word    <= cfg_data;
                    r_idx     <= IW'(WORD_W - 1);
                    prog_in   <= cfg_data[WORD_W-1];
                    cfg_ready <= 1'b0;
                end
                SHIFT_LO: begin
                    r_state  <= SHIFT_HI;
                    prog_clk <= 1'b1;
                end
                SHIFT_HI: begin
                    r_cnt    <= r_cnt + 1'b1;
                    prog_clk <= 1'b0;
                    if (w_last) begin
                        r_state <= TAIL;
                    end else if (r_idx == '0) begin
                        r_state   <= WAIT_WORD;
                        cfg_ready <= 1'b1;
                    end else begin
                        r_state <= SHIFT_LO;
                        r_idx   <= r_idx - 1'b1;
                        prog_in <= r_word[r_idx-1'b1];
                    end
                end
                TAIL: begin
                    r_state <= LATCH;
                    prog_en <= 1'b0;
                end
                LATCH: begin
                    r_state <= DONE;
                    done    <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    prog_in <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef CFG_LOADER_READBACK_EN
    localparam int NW = $clog2(WORD_W + 1);
    logic [WORD_W-1:0] r_rb_sr;
    logic [NW-1:0]     r_rb_n;
    logic [WORD_W-1:0] w_rb_sh;
    assign w_rb_sh = (r_rb_sr << 1) | WORD_W'(prog_out);
    // A trailing partial word is left-aligned and flushed as the shift phase ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb_sr  <= '0;
            r_rb_n   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (r_state == IDLE) begin
                r_rb_n <= '0;
            end else if (r_state == SHIFT_LO) begin
                r_rb_sr <= w_rb_sh;
                if (r_rb_n == NW'(WORD_W - 1)) begin
                    rb_data  <= w_rb_sh;
                    rb_valid <= 1'b1;
                    r_rb_n   <= '0;
                end else begin
                    r_rb_n <= r_rb_n + 1'b1;
                end
            end else if (r_state == SHIFT_HI && w_last && r_rb_n != '0) begin
                rb_data  <= r_rb_sr << (NW'(WORD_W) - r_rb_n);
                rb_valid <= 1'b1;
                r_rb_n   <= '0;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = prog_out;
`endif
endmodule
